// File: rtl/tqvp_hx2003_pulse_receiver.sv
// -----------------------------------------------------------------------------
// tqvp_hx2003_pulse_receiver
// TinyQV peripheral that measures the level segments of a pulse train on one
// ui_in pin. Each segment becomes a 2-bit symbol {level, long}. Symbols are packed
// LSB first, 16 per 32-bit word, into a small symbol memory that can be read
// over the peripheral bus. A frame ends after an idle-level segment of
// idle_timeout ticks, and that raises user_interrupt.
//
// Ports
//   clk            project clock
//   rst            synchronous reset, active high
//   ui_in          input PMOD; ui_in[RX_PIN] is the receive line
//   uo_out         unused output PMOD, driven 0
//   address        register address (0x00 CFG, 0x04 STATUS, 0x20.. symbol words)
//   data_in        bus write data
//   data_write_n   write strobe/size; only 32-bit writes (2'b10) are accepted
//   data_read_n    read strobe; reads have no side effects
//   data_out       read data, decoded combinationally from address
//   data_ready     always 1, every access completes in one cycle
//   user_interrupt done AND irq_en
// -----------------------------------------------------------------------------
module tqvp_hx2003_pulse_receiver #(
    parameter int NUM_DATA_REG = 5,
    parameter int RX_PIN       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    // Count is 8 bits internally so a full 8-word memory (128 symbols) is representable.
    localparam logic [7:0] CAP = 8'(16 * NUM_DATA_REG);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECEIVE    = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    // Symbol for a segment that just ended: its level and whether it reached the threshold.
    function automatic logic [1:0] f_symbol(input logic level, input logic [7:0] dur,
                                            input logic [7:0] thr);
        return {level, (dur >= thr)};
    endfunction

    logic [23:0] r_cfg;
    logic        r_enable_q;
    logic        r_lvl_q;
    logic [14:0] r_pre;
    logic [7:0]  r_dur;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_count;
    logic        r_done;
    logic        r_overflow;
    logic [31:0] r_mem [NUM_DATA_REG];

    logic        w_enable, w_invert, w_idle_level, w_irq_en;
    logic [3:0]  w_prescaler;
    logic [7:0]  w_long_thr, w_idle_to;
    logic        w_lvl, w_edge, w_tick, w_arm, w_timeout, w_emit, w_wr32, w_busy;
    logic [14:0] w_mask;
    logic        w_unused;

    assign w_enable     = r_cfg[0];
    assign w_invert     = r_cfg[1];
    assign w_idle_level = r_cfg[2];
    assign w_prescaler  = r_cfg[6:3];
    assign w_long_thr   = r_cfg[14:7];
    assign w_idle_to    = r_cfg[22:15];
    assign w_irq_en     = r_cfg[23];

    assign w_lvl   = ui_in[RX_PIN] ^ w_invert;
    assign w_edge  = (w_lvl != r_lvl_q);
    // Mask of the low prescaler bits; tick when all of them are set (every 2^p clocks).
    assign w_mask  = (15'd1 << w_prescaler) - 15'd1;
    assign w_tick  = ((r_pre & w_mask) == w_mask);
    assign w_arm   = w_enable & ~r_enable_q;
    assign w_wr32  = (data_write_n == 2'b10);
    assign w_busy  = (r_state == ST_WAIT_START) || (r_state == ST_RECEIVE);

    // The trailing idle segment ends the frame instead of producing a symbol.
    assign w_timeout = (r_state == ST_RECEIVE) && (r_lvl_q == w_idle_level) &&
                       (w_idle_to != 8'd0) && (r_dur == w_idle_to);
    assign w_emit    = (r_state == ST_RECEIVE) && w_edge && !w_timeout && w_enable;

    assign uo_out         = 8'd0;
    assign data_ready     = 1'b1;
    assign user_interrupt = r_done & w_irq_en;
    assign w_unused       = &{1'b0, data_read_n, ui_in, data_in[31:24]};

    // Configuration register and enable history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg      <= 24'd0;
            r_enable_q <= 1'b0;
        end else begin
            r_enable_q <= w_enable;
            if (w_wr32 && (address == 6'h00)) begin
                r_cfg <= data_in[23:0];
            end
        end
    end

    // Input level history and free-running prescaler, restarted on every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_q <= 1'b0;
            r_pre   <= 15'd0;
        end else begin
            r_lvl_q <= w_lvl;
            if (w_edge) begin
                r_pre <= 15'd0;
            end else begin
                r_pre <= r_pre + 15'd1;
            end
        end
    end

    // Segment duration in ticks; only runs while receiving, edge beats tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dur <= 8'd0;
        end else if (r_state != ST_RECEIVE) begin
            r_dur <= 8'd0;
        end else if (w_edge) begin
            r_dur <= 8'd0;
        end else if (w_tick && (r_dur != 8'hFF)) begin
            r_dur <= r_dur + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; clearing enable forces IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) w_state_nxt = ST_WAIT_START;
                else       w_state_nxt = ST_IDLE;
            end
            ST_WAIT_START: begin
                if (r_lvl_q != w_idle_level) w_state_nxt = ST_RECEIVE;
                else                         w_state_nxt = ST_WAIT_START;
            end
            ST_RECEIVE: begin
                if (w_timeout) w_state_nxt = ST_DONE;
                else           w_state_nxt = ST_RECEIVE;
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (!w_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Symbol count and status flags; a timeout beats a simultaneous done-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 8'd0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_arm) begin
            r_count    <= 8'd0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_timeout && w_enable) begin
                r_done <= 1'b1;
            end else if (w_wr32 && (address == 6'h04) && data_in[7]) begin
                r_done <= 1'b0;
            end
            if (w_emit) begin
                if (r_count == CAP) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    // Symbol memory, not reset; each symbol lands in its 2-bit slot at the edge clock.
    always_ff @(posedge clk) begin
        if (!rst && w_emit && (r_count != CAP)) begin
            r_mem[r_count[6:4]][{r_count[3:0], 1'b0} +: 2] <= f_symbol(r_lvl_q, r_dur, w_long_thr);
        end
    end

    // Read mux.
    always_comb begin
        data_out = 32'd0;
        if (address[5]) begin
            if (32'(address[4:2]) < NUM_DATA_REG) begin
                data_out = r_mem[address[4:2]];
            end else begin
                data_out = 32'd0;
            end
        end else begin
            case (address[4:0])
                5'h00:   data_out = {8'd0, r_cfg};
                5'h04:   data_out = {22'd0, w_busy, r_overflow, r_done, r_count[6:0]};
                default: data_out = 32'd0;
            endcase
        end
    end

endmodule
